// File: rtl/adder_bist_pkg.sv
// Shared types and sizing for the adder BIST controller.
// Optional feature macro used by adder_bist: ADDER_BIST_STOP_ON_ERR_EN.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 6;
    localparam int NUM_VECTORS   = 2 ** (2 * DEFAULT_WIDTH);

    // One vector index concatenates both operands.
    function automatic int idx_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden adder: the WIDTH+1-bit sum the device under test must reproduce.
module adder_ref_model
    import adder_bist_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test sweep for a WIDTH-bit ripple adder with error logging.
// Define ADDER_BIST_STOP_ON_ERR_EN to halt the sweep on the first mismatch.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     x,
    output logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     s_in,
    input  logic                 cout_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_err_idx,
    output logic                 first_err_valid
);

    localparam int              IW          = idx_width(WIDTH);
    localparam int              EW          = IW + 1;
    localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0]   IDX_MAX     = '1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);

    state_t          state, state_next;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   settle_cnt;
    logic [WIDTH:0]  golden;
    logic            mismatch;
    logic            stop_on_err;

    adder_ref_model #(.WIDTH(WIDTH)) u_ref (
        .x   (x),
        .y   (y),
        .sum (golden)
    );

    assign mismatch = (golden != {cout_in, s_in});

`ifdef ADDER_BIST_STOP_ON_ERR_EN
    assign stop_on_err = mismatch;
`else
    assign stop_on_err = 1'b0;
`endif

    // Operands come straight from the registered index, so they never glitch.
    assign x    = idx[IW-1:WIDTH];
    assign y    = idx[WIDTH-1:0];
    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_SETTLE;
            S_SETTLE:       if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
            S_CHECK:        state_next = (idx == IDX_MAX || stop_on_err) ? S_DONE : S_SETTLE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx             <= '0;
                        settle_cnt      <= '0;
                        err_count       <= '0;
                        first_err_idx   <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + CW'(1);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + EW'(1);
                        if (!first_err_valid) begin
                            first_err_idx   <= idx;
                            first_err_valid <= 1'b1;
                        end
                    end
                    // The final compare must count toward pass, so use it directly.
                    if (state_next == S_DONE) begin
                        pass <= (err_count == '0) && !mismatch;
                    end else begin
                        idx        <= idx + IW'(1);
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboarded bench for adder_bist: a fault-injectable adder model feeds the DUT.
module tb_adder_bist;
    import adder_bist_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int ST = 1;
    localparam int IW = 2 * W;
`ifdef ADDER_BIST_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam int MID_FAULT = STOP ? 0 : 1;
    localparam int BUDGET    = 20000;

    typedef struct {
        int err_count;
        int first_valid;
        int first_idx;
        int pass;
        int last_idx;
        int done_cycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    x, y, s_in;
    logic            cout_in;
    logic            busy, done, pass;
    logic [IW:0]     err_count;
    logic [IW-1:0]   first_err_idx;
    logic            first_err_valid;

    int   fault = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    adder_bist #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .x               (x),
        .y               (y),
        .s_in            (s_in),
        .cout_in         (cout_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;

    // Fault 1: sum bit 0 stuck at 0. Fault 2: carry-out stuck at 0.
    function automatic logic [W:0] apply_fault(input logic [W:0] g, input int f);
        logic [W:0] r;
        r = g;
        if (f == 1) r[0] = 1'b0;
        if (f == 2) r[W] = 1'b0;
        return r;
    endfunction

    always_comb begin
        logic [W:0] r;
        r = apply_fault({1'b0, x} + {1'b0, y}, fault);
        s_in    = r[W-1:0];
        cout_in = r[W];
    end

    function automatic exp_t compute_expect(input int f);
        exp_t e;
        logic [W-1:0] xv, yv;
        logic [W:0]   g;
        e = '{err_count: 0, first_valid: 0, first_idx: 0, pass: 0, last_idx: 0, done_cycle: 0};
        for (int i = 0; i < (1 << IW); i++) begin
            xv = W'(i >> W);
            yv = W'(i);
            g  = {1'b0, xv} + {1'b0, yv};
            e.last_idx = i;
            if (apply_fault(g, f) != g) begin
                e.err_count++;
                if (e.first_valid == 0) begin
                    e.first_valid = 1;
                    e.first_idx   = i;
                end
                if (STOP) break;
            end
        end
        e.pass       = (e.err_count == 0) ? 1 : 0;
        e.done_cycle = (ST + 1) * (e.last_idx + 1) + 1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".pass"}, 32'(pass), 0);
        check({tag, ".xy"}, 32'({x, y}), 0);
        check({tag, ".err_count"}, 32'(err_count), 0);
        check({tag, ".first_idx"}, 32'(first_err_idx), 0);
        check({tag, ".first_valid"}, 32'(first_err_valid), 0);
    endtask

    // Drive a start pulse at a falling edge; the next rising edge is cycle 0.
    task automatic begin_sweep(input string tag, input int f);
        fault = f;
        sb.push_back(compute_expect(f));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, ".start_busy"}, 32'(busy), 1);
        check({tag, ".start_done"}, 32'(done), 0);
        check({tag, ".start_xy"}, 32'({x, y}), 0);
    endtask

    task automatic wait_vector(input string tag, input int v);
        while ({x, y} != IW'(v) && cyc < BUDGET) tick();
        check({tag, ".reach_vec"}, 32'({x, y}), 32'(v));
    endtask

    task automatic finish_sweep(input string tag);
        exp_t e;
        while (!done && cyc < BUDGET) tick();
        check({tag, ".sb_depth"}, 32'(sb.size()), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".done_cycle"}, 32'(cyc), 32'(e.done_cycle));
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".pass"}, 32'(pass), 32'(e.pass));
        check({tag, ".err_count"}, 32'(err_count), 32'(e.err_count));
        check({tag, ".first_valid"}, 32'(first_err_valid), 32'(e.first_valid));
        check({tag, ".first_idx"}, 32'(first_err_idx), 32'(e.first_idx));
        check({tag, ".final_xy"}, 32'({x, y}), 32'(e.last_idx));
        // done and the results must hold while start stays low.
        tick();
        tick();
        check({tag, ".done_hold"}, 32'(done), 1);
        check({tag, ".pass_hold"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        fault = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        begin_sweep("clean", 0);
        finish_sweep("clean");

        begin_sweep("s0_stuck", 1);
        finish_sweep("s0_stuck");

        begin_sweep("cout_stuck", 2);
        finish_sweep("cout_stuck");

        // Asynchronous reset in the SETTLE cycle of vector 100 discards the run.
        begin_sweep("mid_rst", MID_FAULT);
        wait_vector("mid_rst", 100);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst_idle");

        begin_sweep("after_rst", 0);
        finish_sweep("after_rst");

        // A start pulse while busy must neither restart nor disturb the sweep.
        begin_sweep("busy_start", MID_FAULT);
        wait_vector("busy_start", 500);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start.still_busy", 32'(busy), 1);
        check("busy_start.xy_kept", 32'({x, y}), 500);
        finish_sweep("busy_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Synthesizable built-in self-test controller for the combinational ripple adder (`adder`, ports X, Y, S, cout). It acts as the stimulus-and-check side of the adder interface. It sweeps every operand pair exhaustively and compares the adder response against an internal golden sum. It counts mismatches and records the first failing vector index. It sits beside the adder in on-chip test wrappers, replacing the file-driven simulation bench in silicon.

## Interface
- WIDTH, 6, operand width; vector space is 2^(2*WIDTH).
- SETTLE, 1, cycles (≥1) allowed for adder outputs to settle after operands change.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only when not busy.
- x  out  WIDTH  operand X to adder, registered.
- y  out  WIDTH  operand Y to adder, registered.
- s_in  in  WIDTH  adder sum S.
- cout_in  in  1  adder carry-out.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start or reset.
- pass  out  1  done with zero errors; held with done.
- err_count  out  2*WIDTH+1  mismatch count.
- first_err_idx  out  2*WIDTH  index {x,y} of first mismatch.
- first_err_valid  out  1  first_err_idx holds a captured value.

## Operation
- Reset values: all outputs 0; FSM in IDLE; vector index 0.
- Vector index i is 2*WIDTH bits wide. x = i[2W-1:W], y = i[W-1:0]. Sweep order is y fastest: (0,0),(0,1)…(0,63),(1,0)…(63,63).
- Golden sum: {1'b0,x} + {1'b0,y}, WIDTH+1 bits. A mismatch occurs if bit WIDTH ≠ cout_in or bits [W-1:0] ≠ s_in.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE + start: clear err_count, first_err_valid, first_err_idx, done, pass; load i=0 onto x,y; busy=1; go to SETTLE.
  - SETTLE: wait SETTLE cycles, then go to CHECK.
  - CHECK: compare. On a mismatch, increment err_count. If first_err_valid=0, capture i and set first_err_valid.
    - If i = max: go to DONE.
    - Otherwise: i++, load the new x,y, and go to SETTLE.
  - DONE: busy=0, done=1, pass=(err_count==0 including the final check). Stay in DONE until start.
- start while busy is ignored. No queuing.
- err_count cannot overflow: the maximum is 2^(2W), and the counter width covers it.
- Reset mid-sweep: immediately returns every output and the FSM to reset values. No partial result is retained.
- x and y stay stable from one load until the next CHECK completes.

## Timing
- start sampled high in cycle 0: busy=1 and x=y=0 from cycle 1.
- Each vector occupies SETTLE+1 cycles; the compare happens in the CHECK cycle, using s_in and cout_in sampled on that edge.
- The last CHECK is at cycle 2^(2W)·(SETTLE+1). done and pass rise, and busy falls, on the following edge.
- With defaults, a sweep takes 8192 cycles; done is visible at cycle 8193.
- err_count and first_err_* update on the edge ending the CHECK cycle.

## Configuration
- ADDER_BIST_STOP_ON_ERR_EN defined: on the first mismatch, CHECK goes straight to DONE.
  - err_count=1, pass=0.
  - x and y stay frozen on the failing vector for probing.
- Undefined: the sweep always covers the full vector space, whatever mismatches occur.

## Structure
- Package adder_bist_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the default WIDTH;
  - NUM_VECTORS = 2^(2*WIDTH);
  - the function computing the index width.
- Sub-module adder_ref_model: purely combinational golden adder producing the WIDTH+1-bit expected sum from x and y. It is instantiated once and compared in CHECK.
- Settle counter, index counter, and error registers live in adder_bist.

## Test plan
- Correct adder, defaults, start pulse → done=1 and pass=1 at cycle 8193; err_count=0; first_err_valid=0.
- s[0] stuck at 0 → err_count=2048; first_err_idx=1 (x=0,y=1); pass=0.
- cout stuck at 0 → err_count=2016; first_err_idx=127 (x=1,y=63).
- rst_n low at vector 100 (mid-SETTLE) → all outputs 0 asynchronously. A later start runs a full clean sweep.
- start pulsed at vector 500 while busy → ignored; the sweep completes once; err_count is unchanged by the pulse.
- ADDER_BIST_STOP_ON_ERR_EN with s[0] stuck at 0 → done at vector index 1; err_count=1; x=0, y=1 held; pass=0.
